// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: load, clear, shift/rotate both ways,
// plus a multi-cycle burst engine that repeats one shift/rotate shamt times.
module universal_shift_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] shamt,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           state;
    logic [2:0]       bmode;
    logic [CNT_W-1:0] cnt;
    logic             is_shift;

    function automatic logic [WIDTH-1:0] op(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic             sl,
        input logic             sr,
        input logic [WIDTH-1:0] ld
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (m)
            3'b001:  r = {v[WIDTH-2:0], sr};
            3'b010:  r = {sl, v[WIDTH-1:1]};
            3'b011:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            3'b100:  r = {v[0], v[WIDTH-1:1]};
            3'b101:  r = ld;
            3'b110:  r = RESET_VALUE;
            default: r = v;
        endcase
        return r;
    endfunction

    assign is_shift = (mode != 3'b000) && (mode <= 3'b100);
    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];
    assign busy     = (state == BURST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= RESET_VALUE;
            state <= IDLE;
            bmode <= 3'b000;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && is_shift) begin
                        // Launch edge only latches; a zero count completes at once.
                        if (shamt != '0) begin
                            state <= BURST;
                            bmode <= mode;
                            cnt   <= shamt;
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (en) begin
                        q <= op(mode, q, sin_l, sin_r, d);
                    end
                end
                BURST: begin
                    if (en) begin
                        q   <= op(bmode, q, sin_l, sin_r, d);
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
